// File: rtl/rr_arbiter16_pkg.sv
// Shared definitions for the 16-requester round-robin arbiter.
package rr_arbiter16_pkg;

    localparam int unsigned NREQ  = 16;
    localparam int unsigned IDX_W = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

endpackage

// File: rtl/decoder4x16.sv
// Existing 4-to-16 one-hot decoder. Input bit i[0] is the most significant bit
// of the decoded value.
module decoder4x16 (
    input  logic [3:0]  i,
    output logic [15:0] o
);

    logic [3:0] sel;

    always_comb begin
        sel = {i[0], i[1], i[2], i[3]};
        o   = 16'h0001 << sel;
    end

endmodule

// File: rtl/rr_arbiter16_pick16.sv
// Round-robin winner selection: rotate req so ptr sits at bit 0, pick the
// lowest set bit, then rotate the index back.
import rr_arbiter16_pkg::*;

module rr_pick16 (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] winner,
    output logic             any_req
);

    logic [2*NREQ-1:0] dbl;
    logic [NREQ-1:0]   rot;
    logic [IDX_W-1:0]  off;

    always_comb begin
        dbl = {req, req} >> ptr;
        rot = dbl[NREQ-1:0];
        off = '0;
        // Scan downward so the lowest set bit is the one that sticks.
        for (int unsigned k = NREQ; k > 0; k--) begin
            if (rot[k-1]) begin
                off = IDX_W'(k - 1);
            end
        end
        winner  = ptr + off;
        any_req = |req;
    end

endmodule

// File: rtl/rr_arbiter16.sv
// 16-requester round-robin arbiter with bounded grant hold and a one-cycle
// turnaround gap between consecutive owners.
import rr_arbiter16_pkg::*;

module rr_arbiter16 #(
    parameter int unsigned HOLD_MAX = 8,
    parameter int unsigned CNT_W    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    output logic [NREQ-1:0]      gnt,
    output logic [IDX_W-1:0]     gnt_idx,
    output logic                 gnt_valid,
    output logic                 timeout
);

    // Counter ceiling; with the timeout disabled the counter simply parks at zero.
    localparam logic [CNT_W-1:0] CNT_LAST = (HOLD_MAX == 0) ? '0 : CNT_W'(HOLD_MAX - 1);
    localparam bit               TMO_EN   = (HOLD_MAX != 0);

    state_t            state;
    logic [IDX_W-1:0]  ptr;
    logic [CNT_W-1:0]  cnt;

    logic [IDX_W-1:0]  winner;
    logic              any_req;
    logic [NREQ-1:0]   dec_out;
    logic [NREQ-1:0]   others;
    logic              owner_req;
    logic              competitor;

    rr_pick16 u_pick (
        .req     (req),
        .ptr     (ptr),
        .winner  (winner),
        .any_req (any_req)
    );

    // The decoder reads i[0] as its MSB, so the index goes in bit-reversed.
    decoder4x16 u_dec (
        .i ({gnt_idx[0], gnt_idx[1], gnt_idx[2], gnt_idx[3]}),
        .o (dec_out)
    );

    always_comb begin
        gnt             = dec_out & {NREQ{gnt_valid}};
        owner_req       = req[gnt_idx];
        others          = req;
        others[gnt_idx] = 1'b0;
        competitor      = |others;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
            ptr       <= '0;
            cnt       <= '0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        gnt_idx   <= winner;
                        gnt_valid <= 1'b1;
                        cnt       <= '0;
                        state     <= GRANT;
                    end
                end
                GRANT: begin
                    if (!owner_req) begin
                        gnt_valid <= 1'b0;
                        ptr       <= gnt_idx + 1'b1;
                        state     <= IDLE;
                    end else if (TMO_EN && (cnt == CNT_LAST) && competitor) begin
                        gnt_valid <= 1'b0;
                        timeout   <= 1'b1;
                        ptr       <= gnt_idx + 1'b1;
                        state     <= IDLE;
                    end else if (cnt != CNT_LAST) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_arbiter16.sv
// Directed bench for rr_arbiter16: one instance with the timeout disabled,
// one with HOLD_MAX=4.
module tb_rr_arbiter16;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] req_a, req_b;
    logic [15:0] gnt_a, gnt_b;
    logic [3:0]  idx_a, idx_b;
    logic        vld_a, vld_b;
    logic        tmo_a, tmo_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rr_arbiter16 #(.HOLD_MAX(0), .CNT_W(8)) dut_a (
        .clk       (clk),
        .rst       (rst),
        .req       (req_a),
        .gnt       (gnt_a),
        .gnt_idx   (idx_a),
        .gnt_valid (vld_a),
        .timeout   (tmo_a)
    );

    rr_arbiter16 #(.HOLD_MAX(4), .CNT_W(8)) dut_b (
        .clk       (clk),
        .rst       (rst),
        .req       (req_b),
        .gnt       (gnt_b),
        .gnt_idx   (idx_b),
        .gnt_valid (vld_b),
        .timeout   (tmo_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_a(input string tag, input logic [15:0] g, input logic [3:0] i,
                         input logic v, input logic t);
        chk({tag, ".gnt"}, 32'(gnt_a), 32'(g));
        chk({tag, ".idx"}, 32'(idx_a), 32'(i));
        chk({tag, ".vld"}, 32'(vld_a), 32'(v));
        chk({tag, ".tmo"}, 32'(tmo_a), 32'(t));
    endtask

    task automatic chk_b(input string tag, input logic [15:0] g, input logic [3:0] i,
                         input logic v, input logic t);
        chk({tag, ".gnt"}, 32'(gnt_b), 32'(g));
        chk({tag, ".idx"}, 32'(idx_b), 32'(i));
        chk({tag, ".vld"}, 32'(vld_b), 32'(v));
        chk({tag, ".tmo"}, 32'(tmo_b), 32'(t));
    endtask

    initial begin
        logic [3:0]  own;
        logic [15:0] oh;

        // Reset with every request raised
        rst   = 1'b1;
        req_a = 16'hFFFF;
        req_b = 16'hFFFF;
        tick();
        tick();
        chk_a("rst_a", 16'h0000, 4'd0, 1'b0, 1'b0);
        chk_b("rst_b", 16'h0000, 4'd0, 1'b0, 1'b0);
        rst = 1'b0;
        tick();
        chk_a("first_a", 16'h0001, 4'd0, 1'b1, 1'b0);
        chk_b("first_b", 16'h0001, 4'd0, 1'b1, 1'b0);

        rst   = 1'b1;
        req_a = 16'h0000;
        req_b = 16'h0000;
        tick();
        rst = 1'b0;
        tick();
        chk_a("idle_a", 16'h0000, 4'd0, 1'b0, 1'b0);

        // Rotation between requesters 0 and 15, timeout disabled
        for (int r = 0; r < 4; r++) begin
            own   = (r % 2 == 1) ? 4'd15 : 4'd0;
            oh    = (r % 2 == 1) ? 16'h8000 : 16'h0001;
            req_a = 16'h8001;
            tick();
            chk_a("rot_own1", oh, own, 1'b1, 1'b0);
            tick();
            chk_a("rot_own2", oh, own, 1'b1, 1'b0);
            tick();
            chk_a("rot_own3", oh, own, 1'b1, 1'b0);
            req_a = 16'h8001 & ~oh;
            tick();
            chk_a("rot_gap", 16'h0000, own, 1'b0, 1'b0);
        end

        // Wrap: owner 14 releases so ptr=15, then 0 wins before 3
        req_a = 16'h4000;
        tick();
        chk_a("wrap_own14", 16'h4000, 4'd14, 1'b1, 1'b0);
        req_a = 16'h0009;
        tick();
        chk_a("wrap_gap1", 16'h0000, 4'd14, 1'b0, 1'b0);
        tick();
        chk_a("wrap_win0", 16'h0001, 4'd0, 1'b1, 1'b0);
        req_a = 16'h0008;
        tick();
        chk_a("wrap_gap2", 16'h0000, 4'd0, 1'b0, 1'b0);
        tick();
        chk_a("wrap_win3", 16'h0008, 4'd3, 1'b1, 1'b0);
        req_a = 16'h0000;
        tick();
        tick();
        chk_a("wrap_idle", 16'h0000, 4'd3, 1'b0, 1'b0);

        // Timeout: owner 2 with requester 5 competing, HOLD_MAX=4
        req_b = 16'h0004;
        tick();
        chk_b("tmo_hold1", 16'h0004, 4'd2, 1'b1, 1'b0);
        req_b = 16'h0024;
        tick();
        chk_b("tmo_hold2", 16'h0004, 4'd2, 1'b1, 1'b0);
        tick();
        chk_b("tmo_hold3", 16'h0004, 4'd2, 1'b1, 1'b0);
        tick();
        chk_b("tmo_hold4", 16'h0004, 4'd2, 1'b1, 1'b0);
        tick();
        chk_b("tmo_pulse", 16'h0000, 4'd2, 1'b0, 1'b1);
        tick();
        chk_b("tmo_next5", 16'h0020, 4'd5, 1'b1, 1'b0);
        req_b = 16'h0000;
        tick();
        chk_b("tmo_rel", 16'h0000, 4'd5, 1'b0, 1'b0);
        tick();

        // No competitor: owner 7 keeps the grant indefinitely
        req_b = 16'h0080;
        tick();
        for (int c = 0; c < 50; c++) begin
            chk("solo.gnt", 32'(gnt_b), 32'h0080);
            chk("solo.tmo", 32'(tmo_b), 32'h0);
            tick();
        end

        // Mid-grant reset with owner 9
        req_b = 16'h0200;
        tick();
        chk_b("mid_gap", 16'h0000, 4'd7, 1'b0, 1'b0);
        tick();
        chk_b("mid_own9", 16'h0200, 4'd9, 1'b1, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        chk_b("mid_rst", 16'h0000, 4'd0, 1'b0, 1'b0);
        rst = 1'b0;
        tick();
        chk_b("mid_regrant", 16'h0200, 4'd9, 1'b1, 1'b0);

        // Release on the same edge a timeout would fire counts as voluntary
        req_b = 16'h0201;
        tick();
        tick();
        tick();
        chk_b("vol_hold4", 16'h0200, 4'd9, 1'b1, 1'b0);
        req_b = 16'h0001;
        tick();
        chk_b("vol_rel", 16'h0000, 4'd9, 1'b0, 1'b0);
        tick();
        chk_b("vol_next0", 16'h0001, 4'd0, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
